// File: rtl/multiplier_iterative_booth.sv
// Iterative radix-4 Booth multiplier: one recoded digit per cycle, WIDTH/2+1 cycles per product.
// Handles both signed and unsigned operands by extending them to WIDTH+2 bits.
module multiplier_iterative_booth #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    iter_cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH+1:0] mplier;
    logic             mprev;
    logic [2:0]       triplet;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_next;
    logic             last_iter;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    assign triplet   = {mplier[1:0], mprev};
    assign last_iter = (iter_cnt == CW'(N - 1));
    assign acc_next  = acc + pp;

    // Booth digit selection; arithmetic is modulo 2^(2*WIDTH), which is exact for the kept bits
    always_comb begin
        pp = '0;
        case (triplet)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = {mcand[PW-2:0], 1'b0};
            3'b100:         pp = -{mcand[PW-2:0], 1'b0};
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            mprev    <= 1'b0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
                        mplier   <= {{2{signed_mode & B[WIDTH-1]}}, B};
                        mprev    <= 1'b0;
                        acc      <= '0;
                        iter_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    mcand    <= {mcand[PW-3:0], 2'b00};
                    mplier   <= {2'b00, mplier[WIDTH+1:2]};
                    mprev    <= mplier[1];
                    iter_cnt <= iter_cnt + 1'b1;
                    if (last_iter) begin
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_iterative_booth.sv
// Scoreboard bench for multiplier_iterative_booth: directed corner products, handshake
// stalls, asynchronous abort, random traffic at WIDTH=32 and an exhaustive sweep at WIDTH=4.
module tb_multiplier_iterative_booth;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [31:0] a, b;
    logic [63:0] product;

    logic        s_in_valid, s_in_ready, s_signed_mode, s_out_valid, s_out_ready, s_busy;
    logic [3:0]  s_a, s_b;
    logic [7:0]  s_product;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  s_exp_q[$];

    logic [31:0] vec_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000};
    logic [31:0] vec_b  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 32'h12345678};
    logic        vec_sm [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] vec_p  [6] = '{64'hFFFFFFFE00000001, 64'h0000000000000001, 64'hC000000080000000,
                                64'h4000000000000000, 64'h4000000000000000, 64'h0000000000000000};

    always #5 clk = ~clk;

    multiplier_iterative_booth #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    multiplier_iterative_booth #(.WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_a), .B(s_b), .signed_mode(s_signed_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .product(s_product), .busy(s_busy)
    );

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sm);
        logic [63:0] ex, ey;
        ex = sm ? {{32{x[31]}}, x} : {32'b0, x};
        ey = sm ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic sm);
        logic [7:0] ex, ey;
        ex = sm ? {{4{x[3]}}, x} : {4'b0, x};
        ey = sm ? {{4{y[3]}}, y} : {4'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait (bounded) for acceptance and record its expected product
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic sm);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        a = x; b = y; signed_mode = sm; in_valid = 1'b1;
        exp_q.push_back(ref32(x, y, sm));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic take_result(output logic [63:0] got);
        got = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_signed_mode = 1'b0;
        #12;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        tests_run++;
        if (product !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_product: got %h, required 0", product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] got, expv;
        int lat;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec_a[i], vec_b[i], vec_sm[i]);
            wait_result(lat);
            take_result(got);
            expv = exp_q.pop_front();
            tests_run++;
            if (lat !== 17) begin
                tests_failed++;
                $display("[TB] FAIL latency_%0d: got %0d cycles, required 17", i, lat);
            end
            tests_run++;
            if (got !== expv || got !== vec_p[i]) begin
                tests_failed++;
                $display("[TB] FAIL product_%0d: got %h, required %h", i, got, vec_p[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] p0, expv;
        int lat, bad;
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b1);
        wait_result(lat);
        p0 = product;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; in_valid = ~in_valid;
            tick();
            if (product !== p0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        expv = exp_q.pop_front();
        tests_run++;
        if (bad !== 0 || p0 !== expv) begin
            tests_failed++;
            $display("[TB] FAIL hold_done: %0d unstable cycles, product %h, required %h", bad, p0, expv);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== p0) begin
            tests_failed++;
            $display("[TB] FAIL release_idle: out_valid=%b in_ready=%b product=%h, required 0 1 %h", out_valid, in_ready, product, p0);
        end
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_queue: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_early_ready();
        logic [63:0] got, expv;
        int lat;
        out_ready = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h00C0FFEE, 1'b0);
        repeat (5) tick();
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL early_ready: busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        wait_result(lat);
        got = product;
        expv = exp_q.pop_front();
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (lat + 5 !== 17 || got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL early_ready_result: latency %0d product %h, required 17 %h", lat + 5, got, expv);
        end
    endtask

    task automatic test_abort();
        logic [63:0] got, expv;
        int lat;
        a = 32'h12345678; b = 32'h56781234; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_abort: busy=%b out_valid=%b in_ready=%b product=%h, required 0 0 1 0", busy, out_valid, in_ready, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_abort: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        applyStimulus(32'h3, 32'h5, 1'b0);
        wait_result(lat);
        take_result(got);
        expv = exp_q.pop_front();
        tests_run++;
        if (lat !== 17 || got !== expv || got !== 64'hF) begin
            tests_failed++;
            $display("[TB] FAIL after_abort: latency %0d product %h, required 17 000000000000000f", lat, got);
        end
    endtask

    task automatic test_random32();
        int accepted = 0, done = 0, cyc = 0;
        logic [63:0] expv;
        while (done < 300 && cyc < 30000) begin
            in_valid    = (accepted < 300) && ($urandom_range(0, 3) != 0);
            a           = pick32();
            b           = pick32();
            signed_mode = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref32(a, b, signed_mode));
                accepted++;
            end
            if (out_valid && out_ready) begin
                expv = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
                tests_run++;
                if (product !== expv) begin
                    tests_failed++;
                    $display("[TB] FAIL random32_%0d: got %h, required %h", done, product, expv);
                end
                done++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (done !== 300) begin
            tests_failed++;
            $display("[TB] FAIL random32_timeout: %0d results, required 300", done);
        end
    endtask

    task automatic test_exhaustive4();
        int accepted = 0, done = 0, cyc = 0;
        logic [8:0] kv;
        logic [7:0] expv;
        while (done < 512 && cyc < 20000) begin
            kv            = 9'(accepted);
            s_in_valid    = (accepted < 512) && ($urandom_range(0, 3) != 0);
            s_a           = kv[3:0];
            s_b           = kv[7:4];
            s_signed_mode = kv[8];
            s_out_ready   = ($urandom_range(0, 2) != 0);
            if (s_in_valid && s_in_ready) begin
                s_exp_q.push_back(ref4(s_a, s_b, s_signed_mode));
                accepted++;
            end
            if (s_out_valid && s_out_ready) begin
                expv = (s_exp_q.size() != 0) ? s_exp_q.pop_front() : 8'hx;
                tests_run++;
                if (s_product !== expv) begin
                    tests_failed++;
                    $display("[TB] FAIL exhaustive4_%0d: got %h, required %h", done, s_product, expv);
                end
                done++;
            end
            tick();
            cyc++;
        end
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        tests_run++;
        if (done !== 512) begin
            tests_failed++;
            $display("[TB] FAIL exhaustive4_timeout: %0d results, required 512", done);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_early_ready();
        test_abort();
        test_random32();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multiplier_iterative_booth.md
MULTIPLIER_ITERATIVE_BOOTH -- requirements
Module: multiplier_iterative_booth

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal values are even and >= 4.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operands and mode are presented.
REQ-005 Port: in_ready  output  1  block accepts a new operation.
REQ-006 Port: A  input  WIDTH  multiplicand.
REQ-007 Port: B  input  WIDTH  multiplier.
REQ-008 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 Port: out_valid  output  1  product holds a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: product  output  2*WIDTH  registered result.
REQ-012 Port: busy  output  1  high while in RUN or DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 Acceptance SHALL occur at a rising edge where in_valid=1 and in_ready=1; A, B and signed_mode SHALL be captured at that edge and the FSM SHALL move to RUN.
REQ-016 Operand changes after acceptance SHALL NOT affect the result in flight.
REQ-017 Extension: operands SHALL be extended to WIDTH+2 bits, sign-extended when signed_mode=1 and zero-extended when signed_mode=0.
REQ-018 Recoding: multiplier bits SHALL be radix-4 Booth recoded, one digit in {-2,-1,0,+1,+2} per RUN cycle.
REQ-019 RUN SHALL last exactly N = WIDTH/2+1 cycles, counted by an iteration counter that resets to 0 on acceptance.
REQ-020 After the N-th iteration edge, the FSM SHALL enter DONE, out_valid SHALL be 1, and product SHALL hold the low 2*WIDTH bits of the exact result.
REQ-021 Latency: out_valid SHALL first be seen high N cycles after the acceptance edge (17 for WIDTH=32).
REQ-022 Result width: the result SHALL be the exact product, which fits in 2*WIDTH bits for both modes; no overflow flag.
REQ-023 In DONE, product and out_valid SHALL stay stable until a rising edge with out_ready=1; at that edge the FSM SHALL return to IDLE and out_valid SHALL drop to 0.
REQ-024 out_ready asserted outside DONE SHALL be ignored.
REQ-025 in_valid asserted while busy SHALL be ignored, with no capture and no queuing.
REQ-026 After the output handshake, product SHALL retain the last result until the next DONE entry overwrites it.
REQ-027 Zero operands SHALL run the full N cycles; there is no early termination.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE, and product, out_valid, busy and the iteration counter SHALL be 0; in_ready SHALL be 1.
REQ-029 Assertion of rst_n mid-RUN or in DONE SHALL abort the operation immediately; no stale result is presented after release.
REQ-030 First acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-031 Scenario 1: WIDTH=32, unsigned, A=FFFFFFFF, B=FFFFFFFF -> product=FFFFFFFE00000001, out_valid 17 cycles after acceptance.
REQ-032 Scenario 2: signed, A=FFFFFFFF, B=FFFFFFFF -> product=0000000000000001; signed, A=7FFFFFFF, B=80000000 -> product=C000000080000000.
REQ-033 Scenario 3: signed and unsigned, A=80000000, B=80000000 -> product=4000000000000000 in both modes; A=0, B=12345678 -> product 0 after the full 17 cycles.
REQ-034 Scenario 4: hold out_ready=0 for 10 cycles in DONE, then toggle A, B and in_valid -> product, out_valid and in_ready=0 unchanged; out_ready=1 -> IDLE the next cycle.
REQ-035 Scenario 5: drive rst_n=0 at RUN iteration 8 -> outputs 0 asynchronously; after release, new operation 00000003 x 00000005 -> product=000000000000000F.
REQ-036 Scenario 6: random self-check over 10^5 operations with WIDTH in {4, 8, 32} and both modes against a reference model, including random in_valid/out_ready stalls.
